dct_transpose_buffer: RTL and testbench

- Parametrised N×N ping-pong transpose memory for the row/column 2D-DCT datapath.
- Sits between the 1D row-DCT stage and the 1D column-DCT stage.
- Input words arrive in row-major order and fill one of two banks. Each full bank is drained in column-major order while the other bank fills.
- Replaces the fixed 64×16 single-bank RAM with valid/ready streaming, double buffering and configurable size.

---
 rtl/dct_ram_pkg.sv | 22 ++
 rtl/dct_ram_bank.sv | 42 ++++
 rtl/dct_transpose_buffer.sv | 158 +++++++++++++++
 tb/tb_dct_transpose_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_ram_pkg.sv
// Shared definitions for the 2D-DCT transpose buffer: default sizes, the
// bank-select type and the transposed-address helper.
package dct_ram_pkg;

    localparam int DCT_N_DEF      = 8;
    localparam int DCT_DATA_W_DEF = 16;

    // One bit selects which of the two ping-pong banks is addressed.
    typedef logic bank_sel_t;

    // Column-major read address for linear read index k in an n x n block:
    // row = k mod n becomes the high field, col = k div n the low field.
    // n is always an elaboration-time constant power of two.
    function automatic int xpose_addr(input int k, input int n);
        int row;
        int col;
        row = k % n;
        col = k / n;
        return (row * n) + col;
    endfunction

endpackage

// File: rtl/dct_ram_bank.sv
// Simple dual-port RAM: synchronous write, synchronous read into an output
// register that holds its value unless a read is enabled. The array itself
// is never reset; only the read register clears on reset or i_clr.
module dct_ram_bank #(
    parameter int DATA_W = 16,
    parameter int AW     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<AW)-1];
    logic [DATA_W-1:0] r_rdata;

    // Write port: store the word on every enabled clock edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: load the addressed word, otherwise hold for backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dct_transpose_buffer.sv
// N x N ping-pong transpose buffer between the row-DCT and column-DCT stages.
// Words arrive row-major into one bank while the other full bank drains
// column-major through a registered valid/ready output.
// Optional build macro: DCT_XPOSE_MODE_SEL_EN adds the xpose input, sampled at
// the first read of each block (1 = column-major, 0 = row-major passthrough).
//
// Handshake: a word moves on a port in any cycle where valid && ready at the
// rising edge. in_ready depends only on registered bank state; out_data and
// out_last hold stable while out_valid && !out_ready.
module dct_transpose_buffer
    import dct_ram_pkg::*;
#(
    parameter int DATA_W = DCT_DATA_W_DEF,
    parameter int N      = DCT_N_DEF
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        bank_full
`ifdef DCT_XPOSE_MODE_SEL_EN
    ,
    input  logic              xpose
`endif
);

    localparam int ADDR_W = 2 * $clog2(N);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    bank_sel_t         r_wr_bank;
    bank_sel_t         r_rd_bank;
    logic [1:0]        r_bank_full;
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_in_ready;
    logic              w_wr_acc;
    logic              w_wr_done;
    logic              w_rd_ld;
    logic              w_rd_done;
    logic [1:0]        w_bank_full_nxt;
    logic [ADDR_W-1:0] w_xp_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_ram_we;
    logic              w_ram_re;

    assign w_in_ready = !r_bank_full[r_wr_bank];
    assign w_wr_acc   = in_valid && w_in_ready;
    assign w_wr_done  = w_wr_acc && (&r_wr_ptr);
    assign w_rd_ld    = r_bank_full[r_rd_bank] && (!r_out_valid || out_ready);
    assign w_rd_done  = w_rd_ld && (&r_rd_ptr);
    assign w_xp_addr  = ADDR_W'(xpose_addr(int'(r_rd_ptr), N));

`ifdef DCT_XPOSE_MODE_SEL_EN
    logic r_xpose;
    logic w_xpose_sel;

    // The first read of a block uses the live input; later reads use the latch.
    assign w_xpose_sel = (r_rd_ptr == '0) ? xpose : r_xpose;
    assign w_rd_addr   = w_xpose_sel ? w_xp_addr : r_rd_ptr;

    // Latch the read mode at the first load of each block.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_xpose <= 1'b1;
        end else if (flush) begin
            r_xpose <= 1'b1;
        end else if (w_rd_ld && (r_rd_ptr == '0)) begin
            r_xpose <= xpose;
        end
    end
`else
    assign w_rd_addr = w_xp_addr;
`endif

    // A completing write and a completing read always target different banks.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_wr_done) begin
            w_bank_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_bank_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Pointer, bank and output-flag state; flush behaves like reset at the edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_bank_full <= 2'b00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_bank_full <= 2'b00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_bank_full <= w_bank_full_nxt;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_wr_done) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_rd_ld) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_out_valid <= 1'b1;
                r_out_last  <= &r_rd_ptr;
                if (w_rd_done) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign w_ram_we = w_wr_acc && !flush;
    assign w_ram_re = w_rd_ld && !flush;

    // Both banks live in one array; the bank bit is the address MSB.
    dct_ram_bank #(
        .DATA_W (DATA_W),
        .AW     (ADDR_W + 1)
    ) u_ram (
        .clk     (clk),
        .rst_n   (clr_n),
        .i_clr   (flush),
        .i_we    (w_ram_we),
        .i_waddr ({r_wr_bank, r_wr_ptr}),
        .i_wdata (in_data),
        .i_re    (w_ram_re),
        .i_raddr ({r_rd_bank, w_rd_addr}),
        .o_rdata (out_data)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign bank_full = r_bank_full;

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed bench for dct_transpose_buffer (N=8, DATA_W=16). Expected output
// words, with their last flag, are queued per block before each test.
module tb_dct_transpose_buffer;

    localparam int DATA_W = 16;
    localparam int N      = 8;
    localparam int NN     = N * N;

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [1:0]        bank_full;
    logic              xpose = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int in_left = 0;
    int n_pop = 0;
    int n_acc = 0;
    logic [DATA_W-1:0] in_next = '0;
    logic [DATA_W:0]   exp_q[$];

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    dct_transpose_buffer #(
        .DATA_W (DATA_W),
        .N      (N)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .bank_full (bank_full)
`ifdef DCT_XPOSE_MODE_SEL_EN
        ,
        .xpose     (xpose)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue one block of expected words; tr selects column-major order.
    task automatic push_block(input int base, input bit tr);
        for (int i = 0; i < NN; i++) begin
            int v;
            if (tr) v = base + (i % N) * N + (i / N);
            else    v = base + i;
            exp_q.push_back({(i == NN - 1), DATA_W'(v)});
        end
    endtask

    // One clock: drive inputs, score any output transfer, advance the edge.
    task automatic tick();
        logic acc;
        logic xfer;
        logic [DATA_W:0] e;
        in_valid = (in_left > 0);
        in_data  = in_next;
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (xfer) begin
            if (exp_q.size() == 0) begin
                chk("out_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("out_word", 32'({out_last, out_data}), 32'(e));
                n_pop++;
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            in_left--;
            in_next++;
            n_acc++;
        end
    endtask

    task automatic run_until_empty(input string tag, input int bound);
        for (int i = 0; i < bound && exp_q.size() > 0; i++) tick();
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges, checked while low.
    task automatic do_reset();
        in_left   = 0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1 clr_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_bank_full", 32'(bank_full), 32'd0);
        #1 clr_n = 1'b1;
        exp_q.delete();
        n_pop = 0;
        n_acc = 0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int drops;
        int gaps;
        bit seen;

        // Basic transpose and first-output latency.
        do_reset();
        push_block(0, 1'b1);
        in_next = 0; in_left = NN; out_ready = 1'b1;
        for (int i = 0; i < 100 && in_left > 0; i++) tick();
        chk("t1_wr_done", 32'(in_left), 32'd0);
        chk("t1_full_set", 32'(bank_full), 32'd1);
        chk("t1_no_valid_yet", 32'(out_valid), 32'd0);
        tick();
        chk("t1_first_valid", 32'(out_valid), 32'd1);
        chk("t1_first_data", 32'(out_data), 32'd0);
        chk("t1_first_last", 32'(out_last), 32'd0);
        run_until_empty("t1_drain", 100);
        chk("t1_full_clear", 32'(bank_full), 32'd0);
        chk("t1_valid_drop", 32'(out_valid), 32'd0);

        // Backpressure at output word 10 (value 17).
        do_reset();
        push_block(0, 1'b1);
        in_next = 0; in_left = NN; out_ready = 1'b1;
        for (int i = 0; i < 200 && !(n_pop == 10 && out_valid); i++) tick();
        chk("t2_word10", 32'(out_data), 32'd17);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_data", 32'(out_data), 32'd17);
            chk("t2_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        run_until_empty("t2_drain", 100);

        // Ping-pong stall with both banks full.
        do_reset();
        push_block(0, 1'b1);
        push_block(64, 1'b1);
        in_next = 0; in_left = 2 * NN; out_ready = 1'b0;
        for (int i = 0; i < 300 && in_left > 0; i++) tick();
        chk("t3_wr_done", 32'(in_left), 32'd0);
        chk("t3_in_ready_low", 32'(in_ready), 32'd0);
        chk("t3_both_full", 32'(bank_full), 32'd3);
        chk("t3_out_valid", 32'(out_valid), 32'd1);
        chk("t3_out_data", 32'(out_data), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("t3_still_stalled", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 100 && n_pop < 62; i++) tick();
        chk("t3_pre_free_ready", 32'(in_ready), 32'd0);
        chk("t3_pre_free_full", 32'(bank_full), 32'd3);
        tick();
        chk("t3_freed_ready", 32'(in_ready), 32'd1);
        chk("t3_freed_full", 32'(bank_full), 32'd2);
        run_until_empty("t3_drain", 200);
        chk("t3_full_clear", 32'(bank_full), 32'd0);

        // Concurrent streaming of four blocks.
        do_reset();
        for (int b = 0; b < 4; b++) push_block(b * NN, 1'b1);
        in_next = 0; in_left = 4 * NN; out_ready = 1'b1;
        drops = 0; gaps = 0; seen = 1'b0;
        for (int i = 0; i < 600 && exp_q.size() > 0; i++) begin
            if (n_acc >= NN && in_left > 0 && !in_ready) drops++;
            if (seen && n_pop < 4 * NN && !out_valid) gaps++;
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("t4_drain", 32'(exp_q.size()), 32'd0);
        chk("t4_ready_drops", 32'(drops), 32'd0);
        chk("t4_output_gaps", 32'(gaps), 32'd0);

        // Flush after 30 writes, with a word offered in the flush cycle.
        do_reset();
        in_next = 0; in_left = 30; out_ready = 1'b1;
        for (int i = 0; i < 100 && in_left > 0; i++) tick();
        in_left = 1; in_next = 16'hBEEF; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_bank_full", 32'(bank_full), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        push_block(100, 1'b1);
        in_next = 100; in_left = NN;
        run_until_empty("t5_after_flush", 300);

        // Flush while an output word is pending.
        in_next = 0; in_left = NN; out_ready = 1'b0;
        for (int i = 0; i < 200 && !out_valid; i++) tick();
        chk("t5b_pending", 32'(out_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5b_valid_clear", 32'(out_valid), 32'd0);
        chk("t5b_data_clear", 32'(out_data), 32'd0);
        chk("t5b_full_clear", 32'(bank_full), 32'd0);

        // Asynchronous reset mid-read, then a clean block.
        do_reset();
        push_block(0, 1'b1);
        in_next = 0; in_left = NN; out_ready = 1'b1;
        for (int i = 0; i < 200 && n_pop < 5; i++) tick();
        chk("t6_mid_read", 32'(out_valid), 32'd1);
        do_reset();
        push_block(300, 1'b1);
        in_next = 300; in_left = NN; out_ready = 1'b1;
        run_until_empty("t6_after_reset", 300);

`ifdef DCT_XPOSE_MODE_SEL_EN
        // Passthrough block, then a transposed block.
        do_reset();
        xpose = 1'b0;
        push_block(0, 1'b0);
        in_next = 0; in_left = NN; out_ready = 1'b1;
        run_until_empty("t7_passthrough", 300);
        xpose = 1'b1;
        push_block(64, 1'b1);
        in_next = 64; in_left = NN;
        run_until_empty("t7_transpose", 300);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
